// File: rtl/water_fill_controller.sv
// Drum water fill controller: fills to a load-dependent target, settles, holds
// ready until drained, and faults to drain when a fill overruns its time budget.
module water_fill_controller #(
  parameter int unsigned FILL_TIMEOUT  = 200,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned HYST          = 8,
  parameter int unsigned EMPTY_LEVEL   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       load_ready,
  input  logic [1:0] load_class,
  input  logic [7:0] level_in,
  input  logic       drain_req,
  input  logic       abort,
  input  logic       clear_fault,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       water_ready,
  output logic       fault,
  output logic [7:0] target_level,
  output logic [7:0] fill_cycles
);

  // Timer may step one past FILL_TIMEOUT on the edge that enters FAULT.
  localparam int unsigned TW = $clog2(FILL_TIMEOUT + 2);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SETTLE,
    S_READY,
    S_DRAIN,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    fill_cnt_q, fill_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          fill_valve_q, drain_valve_q, water_ready_q, fault_q;
  logic [7:0]    settle_floor_c;
  logic          empty_c;

  function automatic logic [7:0] class_target(input logic [1:0] cls);
    case (cls)
      2'd0:    class_target = 8'd60;
      2'd1:    class_target = 8'd100;
      2'd2:    class_target = 8'd140;
      default: class_target = 8'd180;
    endcase
  endfunction

  // Level below which a settling drum is considered to have dropped, clamped at 0.
  assign settle_floor_c = (target_q > 8'(HYST)) ? (target_q - 8'(HYST)) : 8'd0;
  assign empty_c        = (level_in <= 8'(EMPTY_LEVEL));

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    fill_cnt_d = fill_cnt_q;
    timer_d    = timer_q;
    settle_d   = settle_q;
    case (state_q)
      S_IDLE: begin
        if (start && load_ready) begin
          state_d    = S_FILL;
          target_d   = class_target(load_class);
          fill_cnt_d = 8'd0;
          timer_d    = '0;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else if (level_in >= target_q) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (fill_cnt_q != 8'hFF) begin
            fill_cnt_d = fill_cnt_q + 8'd1;
          end
          if (timer_q == TW'(FILL_TIMEOUT)) begin
            state_d = S_FAULT;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else if (level_in < settle_floor_c) begin
          state_d = S_FILL;
        end else if (level_in >= target_q) begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d = S_READY;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end else begin
          // Inside the hysteresis band: not a drop, but the run is broken.
          settle_d = '0;
        end
      end
      S_READY: begin
        if (abort || drain_req) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty_c) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (clear_fault && empty_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and decoded outputs share the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      target_q      <= 8'd0;
      fill_cnt_q    <= 8'd0;
      timer_q       <= '0;
      settle_q      <= '0;
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      water_ready_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      fill_cnt_q    <= fill_cnt_d;
      timer_q       <= timer_d;
      settle_q      <= settle_d;
      fill_valve_q  <= (state_d == S_FILL);
      drain_valve_q <= (state_d == S_DRAIN) || (state_d == S_FAULT);
      water_ready_q <= (state_d == S_READY);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign fill_valve   = fill_valve_q;
  assign drain_valve  = drain_valve_q;
  assign water_ready  = water_ready_q;
  assign fault        = fault_q;
  assign target_level = target_q;
  assign fill_cycles  = fill_cnt_q;

endmodule

// File: tb/tb_water_fill_controller.sv
// Bench for water_fill_controller: directed vector table, corner sequences and
// random stimulus compared against a behavioural model of the fill rules.
module tb_water_fill_controller;

  localparam int TO = 200, SETTLE = 4, HYST = 8, EMPTY = 4;
  localparam int M_IDLE = 0, M_FILL = 1, M_SETTLE = 2, M_READY = 3, M_DRAIN = 4, M_FAULT = 5;

  logic clk = 1'b0;
  logic reset;
  logic start, load_ready, drain_req, abort, clear_fault;
  logic [1:0] load_class;
  logic [7:0] level_in;
  logic fill_valve, drain_valve, water_ready, fault;
  logic [7:0] target_level, fill_cycles;

  logic s_start, s_load_ready;
  logic [1:0] s_load_class;
  logic [7:0] s_level_in;
  logic s_fill_valve, s_drain_valve, s_water_ready, s_fault;
  logic [7:0] s_target_level, s_fill_cycles;

  always #5 clk = ~clk;

  water_fill_controller u_dut (
    .clk(clk), .reset(reset), .start(start), .load_ready(load_ready),
    .load_class(load_class), .level_in(level_in), .drain_req(drain_req),
    .abort(abort), .clear_fault(clear_fault), .fill_valve(fill_valve),
    .drain_valve(drain_valve), .water_ready(water_ready), .fault(fault),
    .target_level(target_level), .fill_cycles(fill_cycles)
  );

  water_fill_controller #(.FILL_TIMEOUT(300)) u_sat (
    .clk(clk), .reset(reset), .start(s_start), .load_ready(s_load_ready),
    .load_class(s_load_class), .level_in(s_level_in), .drain_req(1'b0),
    .abort(1'b0), .clear_fault(1'b0), .fill_valve(s_fill_valve),
    .drain_valve(s_drain_valve), .water_ready(s_water_ready), .fault(s_fault),
    .target_level(s_target_level), .fill_cycles(s_fill_cycles)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: phase, latched target, valve-open count, elapsed fill time, settle run.
  int m_phase, m_target, m_fc, m_time, m_run;
  int tgt_tab[4] = '{60, 100, 140, 180};

  typedef struct {
    bit st; bit lr; int cls; int lvl; bit dr; bit ab; bit cf;
    bit e_fill; bit e_drain; bit e_ready; bit e_fault; int e_tgt; int e_fc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pack(input bit f, input bit d, input bit r, input bit fa,
                              input int tgt, input int fc);
    return (int'(f) << 19) | (int'(d) << 18) | (int'(r) << 17) | (int'(fa) << 16) |
           ((tgt & 255) << 8) | (fc & 255);
  endfunction

  function automatic int dut_pack();
    return pack(fill_valve, drain_valve, water_ready, fault, int'(target_level), int'(fill_cycles));
  endfunction

  function automatic int flags();
    return int'({fill_valve, drain_valve, water_ready, fault});
  endfunction

  function automatic int model_pack();
    return pack(m_phase == M_FILL, m_phase == M_DRAIN || m_phase == M_FAULT,
                m_phase == M_READY, m_phase == M_FAULT, m_target, m_fc);
  endfunction

  task automatic m_reset();
    m_phase = M_IDLE; m_target = 0; m_fc = 0; m_time = 0; m_run = 0;
  endtask

  task automatic model_step();
    int lvl;
    int floor_lvl;
    lvl = int'(level_in);
    floor_lvl = (m_target - HYST < 0) ? 0 : m_target - HYST;
    case (m_phase)
      M_IDLE: if (start && load_ready) begin
        m_phase = M_FILL; m_target = tgt_tab[load_class]; m_fc = 0; m_time = 0;
      end
      M_FILL: begin
        if (abort) m_phase = M_DRAIN;
        else if (lvl >= m_target) begin m_phase = M_SETTLE; m_run = 0; end
        else begin
          if (m_time == TO) m_phase = M_FAULT;
          m_time++;
          m_fc = (m_fc < 255) ? m_fc + 1 : 255;
        end
      end
      M_SETTLE: begin
        if (abort) m_phase = M_DRAIN;
        else if (lvl < floor_lvl) m_phase = M_FILL;
        else if (lvl >= m_target) begin
          m_run++;
          if (m_run == SETTLE) m_phase = M_READY;
        end else m_run = 0;
      end
      M_READY: if (abort || drain_req) m_phase = M_DRAIN;
      M_DRAIN: if (lvl <= EMPTY) m_phase = M_IDLE;
      M_FAULT: if (clear_fault && lvl <= EMPTY) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; load_ready = 0; load_class = 0; drain_req = 0; abort = 0; clear_fault = 0;
  endtask

  initial begin
    int n;
    int lvl_r;
    reset = 1'b1;
    idle_inputs();
    level_in = 8'd0;
    s_start = 0; s_load_ready = 0; s_load_class = 0; s_level_in = 8'd0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", dut_pack(), 0);
    chk("reset_state_sat", int'({s_fill_valve, s_drain_valve, s_water_ready, s_fault,
                                 s_target_level, s_fill_cycles}), 0);
    reset = 1'b0;

    //          st lr cls lvl dr ab cf | fill drain ready fault tgt fc
    tbl.push_back('{1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0,   0, 0});
    tbl.push_back('{1, 1, 0,   0, 0, 0, 0, 1, 0, 0, 0,  60, 0});
    tbl.push_back('{0, 0, 0,  59, 0, 0, 0, 1, 0, 0, 0,  60, 1});
    tbl.push_back('{0, 0, 0,  60, 0, 0, 0, 0, 0, 0, 0,  60, 1});
    tbl.push_back('{0, 0, 0,  55, 0, 0, 0, 0, 0, 0, 0,  60, 1});
    tbl.push_back('{0, 0, 0,  51, 0, 0, 0, 1, 0, 0, 0,  60, 1});
    tbl.push_back('{0, 0, 0,  51, 0, 0, 0, 1, 0, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,  70, 0, 0, 0, 0, 0, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,  70, 0, 0, 0, 0, 0, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,  70, 0, 0, 0, 0, 0, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,  70, 0, 0, 0, 0, 0, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,  70, 0, 0, 0, 0, 0, 1, 0,  60, 2});
    tbl.push_back('{1, 1, 3,  70, 0, 0, 0, 0, 0, 1, 0,  60, 2});
    tbl.push_back('{0, 0, 0,  70, 1, 0, 0, 0, 1, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,   5, 0, 0, 0, 0, 1, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,   4, 0, 1, 0, 0, 0, 0, 0,  60, 2});
    tbl.push_back('{0, 0, 0,   4, 0, 1, 0, 0, 0, 0, 0,  60, 2});
    tbl.push_back('{1, 1, 3, 200, 0, 0, 0, 1, 0, 0, 0, 180, 0});
    tbl.push_back('{0, 0, 0, 200, 0, 0, 0, 0, 0, 0, 0, 180, 0});
    tbl.push_back('{0, 0, 0, 200, 0, 1, 0, 0, 1, 0, 0, 180, 0});
    tbl.push_back('{0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0, 180, 0});
    tbl.push_back('{1, 1, 0,   0, 0, 0, 0, 1, 0, 0, 0,  60, 0});
    tbl.push_back('{0, 0, 0,   0, 0, 1, 0, 0, 1, 0, 0,  60, 0});
    tbl.push_back('{0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0,  60, 0});
    foreach (tbl[i]) begin
      start = tbl[i].st; load_ready = tbl[i].lr; load_class = 2'(tbl[i].cls);
      level_in = 8'(tbl[i].lvl); drain_req = tbl[i].dr; abort = tbl[i].ab;
      clear_fault = tbl[i].cf;
      cycle();
      chk($sformatf("table_%0d", i), dut_pack(),
          pack(tbl[i].e_fill, tbl[i].e_drain, tbl[i].e_ready, tbl[i].e_fault,
               tbl[i].e_tgt, tbl[i].e_fc));
    end
    idle_inputs();

    // Nominal ramp of +2 per cycle to the class-1 target.
    level_in = 8'd0; start = 1; load_ready = 1; load_class = 2'd1;
    cycle();
    idle_inputs();
    chk("nominal_enter_fill", int'(fill_valve), 1);
    for (int i = 0; i < 60 && fill_valve; i++) begin
      level_in = 8'(2 * i);
      cycle();
      chk_model_ramp: chk("nominal_ramp", dut_pack(), model_pack());
    end
    level_in = 8'd100;
    repeat (3) cycle();
    chk("nominal_settle_not_ready", int'(water_ready), 0);
    cycle();
    chk("nominal_ready", int'(water_ready), 1);
    chk("nominal_fill_cycles", int'(fill_cycles), 50);

    // Abort from READY, then drain to empty.
    abort = 1; cycle(); abort = 0;
    chk("abort_ready_to_drain", flags(), 4'b0100);
    level_in = 8'd20; cycle();
    chk("drain_hold", flags(), 4'b0100);
    level_in = 8'd4; cycle();
    chk("drain_to_idle_flags", flags(), 0);

    // Settle dip below target-HYST returns to FILL.
    level_in = 8'd0; start = 1; load_ready = 1; load_class = 2'd2;
    cycle(); idle_inputs();
    level_in = 8'd139; cycle();
    level_in = 8'd140; cycle();
    chk("dip_in_settle", flags(), 0);
    level_in = 8'd135; cycle();
    chk("dip_band_holds", flags(), 0);
    level_in = 8'd130; cycle();
    chk("dip_back_to_fill", dut_pack(), pack(1, 0, 0, 0, 140, 1));
    level_in = 8'd140;
    repeat (5) begin cycle(); chk("dip_resettle", dut_pack(), model_pack()); end
    chk("dip_ready", int'(water_ready), 1);
    drain_req = 1; cycle(); drain_req = 0;
    level_in = 8'd0; cycle();
    chk("dip_idle", dut_pack(), model_pack());

    // Timeout with a mid-fill dip: the timer keeps running across SETTLE.
    level_in = 8'd10; start = 1; load_ready = 1; load_class = 2'd0;
    cycle(); idle_inputs();
    repeat (100) cycle();
    chk("timeout_first_leg", dut_pack(), model_pack());
    level_in = 8'd60; cycle();
    level_in = 8'd40; cycle();
    chk("timeout_refill", int'(fill_valve), 1);
    level_in = 8'd10;
    n = 0;
    while (!fault && n < 400) begin cycle(); n++; end
    chk("timeout_cycles_after_dip", n, 101);
    chk("timeout_fault_state", dut_pack(), pack(0, 1, 0, 1, 60, 201));
    clear_fault = 1; cycle();
    chk("fault_clear_not_empty", flags(), 4'b0101);
    clear_fault = 0; level_in = 8'd3; cycle();
    chk("fault_empty_no_clear", flags(), 4'b0101);
    clear_fault = 1; cycle(); clear_fault = 0;
    chk("fault_cleared", dut_pack(), pack(0, 0, 0, 0, 60, 201));

    // Asynchronous reset between edges during FILL.
    level_in = 8'd0; start = 1; load_ready = 1; load_class = 2'd1;
    cycle(); idle_inputs();
    @(posedge clk);
    model_step();
    #2 reset = 1'b1;
    #1 chk("async_reset_valve", int'(fill_valve), 0);
    chk("async_reset_outputs", dut_pack(), 0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1; load_ready = 0; load_class = 2'd1;
    cycle();
    chk("start_without_load_ready", dut_pack(), 0);
    cycle(); idle_inputs();
    chk("still_idle", dut_pack(), 0);

    // Saturating fill counter on the long-timeout instance.
    s_start = 1; s_load_ready = 1; s_load_class = 2'd3; s_level_in = 8'd0;
    @(posedge clk); @(negedge clk);
    s_start = 0; s_load_ready = 0;
    n = 0;
    while (!s_fault && n < 400) begin
      s_level_in = 8'(n / 2);
      @(posedge clk); @(negedge clk);
      n++;
      if (n == 254 || n == 255 || n == 256 || n == 300)
        chk($sformatf("sat_fc_at_%0d", n), int'(s_fill_cycles), (n < 255) ? n : 255);
    end
    chk("sat_fault_cycles", n, 301);
    chk("sat_final_fc", int'(s_fill_cycles), 255);

    // Random stimulus against the model.
    lvl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 9) < 3);
      load_ready  = ($urandom_range(0, 9) < 7);
      load_class  = 2'($urandom_range(0, 3));
      drain_req   = ($urandom_range(0, 9) == 0);
      abort       = ($urandom_range(0, 49) == 0);
      clear_fault = ($urandom_range(0, 4) == 0);
      lvl_r = lvl_r + int'($urandom_range(0, 8)) - 3;
      if (m_phase == M_DRAIN || m_phase == M_FAULT) lvl_r = lvl_r - 4;
      if ($urandom_range(0, 49) == 0) lvl_r = int'($urandom_range(0, 255));
      if (lvl_r < 0) lvl_r = 0;
      if (lvl_r > 255) lvl_r = 255;
      level_in = 8'(lvl_r);
      cycle();
      chk("random", dut_pack(), model_pack());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/water_fill_controller.md
WATER_FILL_CONTROLLER -- requirements
Module: water_fill_controller

Interface
REQ-001 SHALL provide parameter FILL_TIMEOUT, default 200, the maximum number of cycles allowed in FILL before a fault.
REQ-002 SHALL provide parameter SETTLE_CYCLES, default 4, the number of cycles the level must hold at or above target before ready.
REQ-003 SHALL provide parameter HYST, default 8, the settle-phase drop margin below target.
REQ-004 SHALL provide parameter EMPTY_LEVEL, default 4, the level at or below which the drum counts as empty.
REQ-005 SHALL provide port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-006 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide port start, input, 1, fill request from control unit.
REQ-008 SHALL provide port load_ready, input, 1, load sensing complete.
REQ-009 SHALL provide port load_class, input, 2, load weight class from load sensing.
REQ-010 SHALL provide port level_in, input, 8, unsigned drum water level sensor.
REQ-011 SHALL provide port drain_req, input, 1, request to drain after the cycle.
REQ-012 SHALL provide port abort, input, 1, emergency stop.
REQ-013 SHALL provide port clear_fault, input, 1, operator fault acknowledge.
REQ-014 SHALL provide port fill_valve, output, 1, inlet valve open.
REQ-015 SHALL provide port drain_valve, output, 1, drain pump on.
REQ-016 SHALL provide port water_ready, output, 1, water at target (feeds temperature control).
REQ-017 SHALL provide port fault, output, 1, fill timeout fault.
REQ-018 SHALL provide port target_level, output, 8, latched fill target.
REQ-019 SHALL provide port fill_cycles, output, 8, saturating count of valve-open cycles (energy accounting).

Function
REQ-020 SHALL implement states IDLE, FILL, SETTLE, READY, DRAIN, FAULT in one state register; all outputs are Moore-decoded from registered state/counters.
REQ-021 SHALL drive outputs by state: fill_valve=1 only in FILL; drain_valve=1 only in DRAIN and FAULT; water_ready=1 only in READY; fault=1 only in FAULT.
REQ-022 IDLE: on start=1 AND load_ready=1, SHALL go to FILL, latch target_level from load_class (0->60, 1->100, 2->140, 3->180), and clear fill_cycles and the timer; start without load_ready is ignored.
REQ-023 FILL: each cycle with level_in < target_level, SHALL increment the timer and fill_cycles (fill_cycles saturates at 255, no wrap).
REQ-024 FILL: when level_in >= target_level, SHALL go to SETTLE and clear the settle counter.
REQ-025 FILL: when the timer equals FILL_TIMEOUT and level_in < target_level, SHALL go to FAULT; if level reaches target in the same cycle, SETTLE wins.
REQ-026 SETTLE: SHALL count cycles; if level_in < target_level-HYST (unsigned compare, clamped at 0), SHALL return to FILL without clearing the timer; after SETTLE_CYCLES consecutive cycles, SHALL go to READY.
REQ-027 READY: SHALL hold until drain_req=1, then go to DRAIN.
REQ-028 DRAIN: SHALL go to IDLE when level_in <= EMPTY_LEVEL.
REQ-029 abort=1 in FILL, SETTLE or READY SHALL go to DRAIN next edge, overriding all other transitions; abort SHALL be ignored in IDLE, DRAIN and FAULT.
REQ-030 FAULT: drain_valve stays on and the state SHALL hold until clear_fault=1 AND level_in <= EMPTY_LEVEL, then go to IDLE.
REQ-031 target_level and fill_cycles SHALL hold their values outside FILL until the next accepted start.
REQ-032 Latency: the rising edge that samples a qualifying input SHALL be the edge on which the state and outputs change, with no extra pipeline stage.

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE, target_level=0, fill_cycles=0, and timer and settle counter to 0, so all outputs are 0 while reset is high.
REQ-034 Reset asserted mid-fill SHALL close the valve immediately, without waiting for a clock edge; after release the block waits in IDLE for a new start.

Verification
REQ-035 Nominal fill: load_class=1, start+load_ready, level ramps +2/cycle from 0 -> fill_valve high until level>=100, then 4 SETTLE cycles, then water_ready=1; fill_cycles=50.
REQ-036 Timeout: level_in stuck at 10, class 0 -> fault=1 and drain_valve=1 after 200 FILL cycles; clear_fault with level 3 -> IDLE.
REQ-037 Settle dip: level reaches 140 (class 2), drops to 130 during SETTLE -> back to FILL, fill_valve=1, timer not reset.
REQ-038 Abort in READY -> DRAIN next edge; level falls to 4 -> IDLE with all outputs 0.
REQ-039 Async reset asserted between clock edges during FILL -> fill_valve=0 before the next edge; start with load_ready=0 after release -> remains IDLE.
REQ-040 Saturation: FILL_TIMEOUT=300 override with a slow ramp -> fill_cycles holds at 255.
